// File: rtl/readback_arbiter.sv
// Round-robin arbiter merging NUM_CH packet sources into the readback FIFO write port, tagging each packet with a header.
// Latency: grant registered one cycle after ch_req seen in IDLE; header written in the grant cycle if fifo_ready.
// Backpressure: fifo_ready=0 stalls HDR/DATA/PAD indefinitely; ch_ready follows fifo_ready; stalls never count toward timeout.
`timescale 1ns/1ps
module readback_arbiter #(
    parameter int          NUM_CH   = 4,
    parameter int          DATA_W   = 32,
    parameter int          LEN_W    = 8,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] PAD_WORD = 32'hDEADBEEF
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_grant,
    input  logic                     fifo_ready,
    output logic                     fifo_write,
    output logic [DATA_W-1:0]        fifo_data,
    input  logic                     clear_err,
    output logic [NUM_CH-1:0]        timeout_flag,
    output logic                     busy
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;

    typedef struct packed {
        logic [7:0] marker;
        logic [7:0] ch_id;
        logic [7:0] seq;
        logic [7:0] len;
    } hdr_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_id_q, gnt_id_d;
    logic [PTR_W-1:0]   winner, arb_idx;
    logic               found;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic [7:0]         seq_q [NUM_CH];
    logic               seq_inc;
    logic [NUM_CH-1:0]  flag_set;
    hdr_t               hdr;

    logic [LEN_W-1:0]   len_arr  [NUM_CH];
    logic [DATA_W-1:0]  data_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign len_arr[g]  = ch_len[g*LEN_W +: LEN_W];
        assign data_arr[g] = ch_data[g*DATA_W +: DATA_W];
    end

    // First requesting channel at or after ptr, wrapping.
    always_comb begin
        winner  = '0;
        arb_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = PTR_W'((int'(ptr_q) + i) % NUM_CH);
            if (!found && ch_req[arb_idx]) begin
                winner = arb_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_id_d   = gnt_id_q;
        rem_d      = rem_q;
        idle_d     = idle_q;
        seq_inc    = 1'b0;
        flag_set   = '0;
        fifo_write = 1'b0;
        fifo_data  = '0;
        ch_ready   = '0;
        ch_grant   = '0;

        hdr.marker = 8'hA5;
        hdr.ch_id  = 8'(gnt_id_q);
        hdr.seq    = seq_q[gnt_id_q];
        hdr.len    = 8'(rem_q);

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (found) begin
                    state_d  = HDR;
                    gnt_id_d = winner;
                    rem_d    = len_arr[winner];
                    ptr_d    = (winner == PTR_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
                end
            end
            HDR: begin
                ch_grant[gnt_id_q] = 1'b1;
                fifo_write         = fifo_ready;
                fifo_data          = DATA_W'(hdr);
                if (fifo_ready) begin
                    seq_inc = 1'b1;
                    idle_d  = '0;
                    state_d = (rem_q != '0) ? DATA : IDLE;
                end
            end
            DATA: begin
                ch_grant[gnt_id_q] = 1'b1;
                ch_ready[gnt_id_q] = fifo_ready;
                fifo_write         = fifo_ready & ch_valid[gnt_id_q];
                fifo_data          = data_arr[gnt_id_q];
                if (fifo_write) begin
                    rem_d  = rem_q - 1'b1;
                    idle_d = '0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end else if (fifo_ready) begin
                    // Only cycles where the FIFO could have taken a word count as source idle.
                    if (idle_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d            = PAD;
                        flag_set[gnt_id_q] = 1'b1;
                        idle_d             = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            PAD: begin
                ch_grant[gnt_id_q] = 1'b1;
                fifo_write         = fifo_ready;
                fifo_data          = DATA_W'(PAD_WORD);
                if (fifo_ready) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            rem_q    <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            rem_q    <= rem_d;
            idle_q   <= idle_d;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                seq_q[i] <= '0;
            end
        end else if (seq_inc) begin
            seq_q[gnt_id_q] <= seq_q[gnt_id_q] + 8'd1;
        end
    end

    // A new timeout beats a simultaneous clear.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_flag <= '0;
        end else begin
            timeout_flag <= (timeout_flag & ~{NUM_CH{clear_err}}) | flag_set;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_readback_arbiter.sv
// Directed bench for readback_arbiter: header/data framing, round-robin order, timeout padding,
// backpressure, sequence wrap and mid-packet reset.
`timescale 1ns/1ps
module tb_readback_arbiter;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 1024;

    logic                     sys_clk = 1'b0;
    logic                     reset_n;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_grant;
    logic                     fifo_ready;
    logic                     fifo_write;
    logic [DATA_W-1:0]        fifo_data;
    logic                     clear_err;
    logic [NUM_CH-1:0]        timeout_flag;
    logic                     busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] wq [$];
    logic [31:0] src_q [NUM_CH][$];
    logic        wr_full_seen = 1'b0;

    readback_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .TIMEOUT(TIMEOUT), .PAD_WORD(32'hDEADBEEF)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .ch_req(ch_req), .ch_len(ch_len), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .ch_grant(ch_grant),
        .fifo_ready(fifo_ready), .fifo_write(fifo_write), .fifo_data(fifo_data),
        .clear_err(clear_err), .timeout_flag(timeout_flag), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO-side capture, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (reset_n && fifo_write) begin
            wq.push_back(fifo_data);
            if (!fifo_ready) wr_full_seen = 1'b1;
        end
    end

    // Source model: each channel presents the head of its queue, popped when accepted.
    initial begin : src_model
        logic [NUM_CH-1:0] acc;
        ch_valid = '0;
        ch_data  = '0;
        forever begin
            @(negedge sys_clk);
            acc = reset_n ? (ch_ready & ch_valid) : '0;
            @(posedge sys_clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c] && src_q[c].size() > 0) src_q[c].delete(0);
                ch_valid[c] = (src_q[c].size() > 0);
                ch_data[c*DATA_W +: DATA_W] = (src_q[c].size() > 0) ? src_q[c][0] : 32'h0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        if (wq.size() > 0) obs = wq.pop_front();
        else               obs = 'x;
        chk(tag, obs, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Waits for the grant pattern, then drops all requests after the grant edge.
    task automatic wait_grant(input string tag, input logic [NUM_CH-1:0] g, input int budget);
        int c = 0;
        @(negedge sys_clk);
        while (ch_grant !== g && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        chk(tag, 32'(ch_grant), 32'(g));
        step();
        ch_req = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        @(negedge sys_clk);
        while (busy && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int c = 0;
        while (wq.size() < n && c < budget) begin
            @(posedge sys_clk);
            c++;
        end
        chk(tag, 32'(wq.size()), 32'(n));
    endtask

    initial begin : main
        logic [31:0] e;
        reset_n    = 1'b0;
        ch_req     = '0;
        ch_len     = '0;
        fifo_ready = 1'b1;
        clear_err  = 1'b0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_grant", 32'(ch_grant), 32'd0);
        chk("rst_ready", 32'(ch_ready), 32'd0);
        chk("rst_write", 32'(fifo_write), 32'd0);
        chk("rst_data",  fifo_data, 32'd0);
        chk("rst_flag",  32'(timeout_flag), 32'd0);
        step();
        reset_n = 1'b1;

        // 1: single ch0 packet, grant latency, length change after grant ignored
        step();
        for (int i = 1; i <= 3; i++) src_q[0].push_back(32'(i));
        ch_len[7:0] = 8'd3;
        ch_req      = 4'b0001;
        @(negedge sys_clk);
        chk("t1_grant_before", 32'(ch_grant), 32'd0);
        @(negedge sys_clk);
        chk("t1_grant",   32'(ch_grant), 32'h1);
        chk("t1_hdr_wr",  32'(fifo_write), 32'd1);
        chk("t1_hdr_dat", fifo_data, 32'hA5000003);
        step();
        ch_req      = '0;
        ch_len[7:0] = 8'd9;
        wait_idle("t1_idle", 50);
        chk("t1_count", 32'(wq.size()), 32'd4);
        pop_chk("t1_hdr", 32'hA5000003);
        pop_chk("t1_d1", 32'h1);
        pop_chk("t1_d2", 32'h2);
        pop_chk("t1_d3", 32'h3);

        // ch3 header-only packet moves the pointer back to 0
        step();
        ch_len = '0;
        ch_req = 4'b1000;
        wait_grant("t1b_grant", 4'b1000, 10);
        wait_idle("t1b_idle", 20);
        chk("t1b_count", 32'(wq.size()), 32'd1);
        pop_chk("t1b_hdr", 32'hA5030000);

        // 2: all channels held, header-only packets in round-robin order
        step();
        ch_req = 4'b1111;
        wait_writes("t2_writes", 5, 50);
        #1;
        ch_req = '0;
        wait_idle("t2_idle", 20);
        chk("t2_count", 32'(wq.size()), 32'd5);
        pop_chk("t2_h0", 32'hA5000100);
        pop_chk("t2_h1", 32'hA5010000);
        pop_chk("t2_h2", 32'hA5020000);
        pop_chk("t2_h3", 32'hA5030100);
        pop_chk("t2_h4", 32'hA5000200);

        // 3: ch1 stalls mid-packet, padded after TIMEOUT idle cycles
        step();
        src_q[1].push_back(32'h11);
        src_q[1].push_back(32'h12);
        ch_len[15:8] = 8'd4;
        ch_req       = 4'b0010;
        wait_grant("t3_grant", 4'b0010, 10);
        wait_writes("t3_partial", 3, 20);
        repeat (TIMEOUT - 100) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t3_no_early_pad", 32'(wq.size()), 32'd3);
        chk("t3_no_early_flag", 32'(timeout_flag), 32'd0);
        chk("t3_still_busy", 32'(busy), 32'd1);
        wait_idle("t3_idle", 300);
        chk("t3_count", 32'(wq.size()), 32'd5);
        pop_chk("t3_hdr", 32'hA5010104);
        pop_chk("t3_d1", 32'h11);
        pop_chk("t3_d2", 32'h12);
        pop_chk("t3_pad1", 32'hDEADBEEF);
        pop_chk("t3_pad2", 32'hDEADBEEF);
        chk("t3_flag", 32'(timeout_flag), 32'h2);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        @(negedge sys_clk);
        chk("t3_flag_clr", 32'(timeout_flag), 32'd0);

        // 4: long FIFO backpressure mid-packet is not a timeout
        step();
        for (int i = 0; i < 3; i++) src_q[2].push_back(32'h21 + 32'(i));
        ch_len[23:16] = 8'd3;
        ch_req        = 4'b0100;
        wait_grant("t4_grant", 4'b0100, 10);
        wait_writes("t4_partial", 2, 20);
        #1;
        fifo_ready = 1'b0;
        repeat (5000) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t4_frozen", 32'(wq.size()), 32'd2);
        chk("t4_no_flag", 32'(timeout_flag), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        step();
        fifo_ready = 1'b1;
        wait_idle("t4_idle", 50);
        chk("t4_count", 32'(wq.size()), 32'd4);
        pop_chk("t4_hdr", 32'hA5020103);
        pop_chk("t4_d1", 32'h21);
        pop_chk("t4_d2", 32'h22);
        pop_chk("t4_d3", 32'h23);
        chk("t4_flag_after", 32'(timeout_flag), 32'd0);

        // 5: 257 back-to-back ch2 headers, seq wraps through FF -> 00
        step();
        ch_len = '0;
        ch_req = 4'b0100;
        wait_writes("t5_writes", 257, 1000);
        #1;
        ch_req = '0;
        wait_idle("t5_idle", 20);
        chk("t5_count", 32'(wq.size()), 32'd257);
        for (int i = 0; i < 257; i++) begin
            e = {8'hA5, 8'h02, 8'(i + 2), 8'h00};
            pop_chk($sformatf("t5_hdr%0d", i), e);
        end

        // 6: asynchronous reset in the middle of a ch3 packet
        step();
        for (int i = 0; i < 5; i++) src_q[3].push_back(32'h31 + 32'(i));
        ch_len[31:24] = 8'd5;
        ch_req        = 4'b1000;
        wait_grant("t6_grant", 4'b1000, 10);
        wait_writes("t6_partial", 2, 20);
        #1;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        chk("t6_ready_pre", 32'(ch_ready), 32'h8);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_write", 32'(fifo_write), 32'd0);
        chk("t6_rst_grant", 32'(ch_grant), 32'd0);
        chk("t6_rst_ready", 32'(ch_ready), 32'd0);
        chk("t6_rst_busy",  32'(busy), 32'd0);
        chk("t6_rst_data",  fifo_data, 32'd0);
        src_q[3].delete();
        wq.delete();
        step();
        reset_n = 1'b1;
        step();
        ch_len = '0;
        ch_req = 4'b1000;
        wait_grant("t6_grant2", 4'b1000, 10);
        wait_idle("t6_idle", 20);
        chk("t6_count", 32'(wq.size()), 32'd1);
        pop_chk("t6_hdr_seq0", 32'hA5030000);

        chk("no_write_when_full", 32'(wr_full_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
